// File: rtl/operand_stage_pkg.sv
// operand_stage_pkg: uop formats, functional-unit encoding and enable mapping
// shared by the operand-read stage.
`default_nettype none

package operand_stage_pkg;

   localparam int C_TAG_W = 6;
   localparam int C_XLEN  = 32;
   localparam int C_SQN_W = 6;
   localparam int C_NM_W  = 5;
   localparam int C_OPC_W = 6;
   localparam int C_BID_W = 3;

   typedef enum logic [2:0] {
      FU_INT    = 3'd0,
      FU_LSU    = 3'd1,
      FU_MUL    = 3'd2,
      FU_DIV    = 3'd3,
      FU_FPU    = 3'd4,
      FU_BRANCH = 3'd5
   } FuncUnit;

   localparam logic [3:0] C_EN_INT  = 4'b0001;
   localparam logic [3:0] C_EN_LSU  = 4'b0010;
   localparam logic [3:0] C_EN_MUL  = 4'b0100;
   localparam logic [3:0] C_EN_DIV  = 4'b1000;
   localparam logic [3:0] C_EN_NONE = 4'b0000;

   typedef struct packed {
      logic [C_XLEN-1:0]  imm;
      logic               immB;
      logic [C_TAG_W-1:0] tagA;
      logic [C_TAG_W-1:0] tagB;
      logic [C_SQN_W-1:0] sqN;
      logic [C_TAG_W-1:0] tagDst;
      logic [C_NM_W-1:0]  nmDst;
      logic [C_OPC_W-1:0] opcode;
      FuncUnit            fu;
      logic [C_XLEN-1:0]  pc;
      logic [C_BID_W-1:0] branchID;
      logic               branchPred;
      logic [C_SQN_W-1:0] loadSqN;
      logic [C_SQN_W-1:0] storeSqN;
      logic               compressed;
   } R_UOp;

   typedef struct packed {
      logic [C_XLEN-1:0]  srcA;
      logic [C_XLEN-1:0]  srcB;
      logic [C_XLEN-1:0]  imm;
      logic [C_SQN_W-1:0] sqN;
      logic [C_TAG_W-1:0] tagDst;
      logic [C_NM_W-1:0]  nmDst;
      logic [C_OPC_W-1:0] opcode;
      logic [C_XLEN-1:0]  pc;
      logic [C_BID_W-1:0] branchID;
      logic               branchPred;
      logic [C_SQN_W-1:0] loadSqN;
      logic [C_SQN_W-1:0] storeSqN;
      logic               compressed;
   } EX_UOp;

   typedef struct packed {
      logic [C_XLEN-1:0]  result;
      logic [C_TAG_W-1:0] tagDst;
   } RES_UOp;

   function automatic logic [3:0] fu_enable(input FuncUnit fu);
      case (fu)
         FU_INT:  return C_EN_INT;
         FU_LSU:  return C_EN_LSU;
         FU_MUL:  return C_EN_MUL;
         FU_DIV:  return C_EN_DIV;
         default: return C_EN_NONE;
      endcase
   endfunction

   // Wrap-safe age compare: a is younger than b when (a - b) is positive.
   function automatic logic is_younger(input logic [C_SQN_W-1:0] a,
                                       input logic [C_SQN_W-1:0] b);
      logic [C_SQN_W-1:0] d;
      d = a - b;
      return $signed(d) > 0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/operand_skid.sv
// operand_skid: one port's output register plus a single skid entry, with
// flush-by-age and skid promotion.
`default_nettype none

module operand_skid
   import operand_stage_pkg::*;
#(
   parameter int NUM_XUS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   input  EX_UOp              i_uop,
   input  logic [NUM_XUS-1:0] i_en,
   input  logic               i_ready,
   input  logic               i_inv,
   input  logic [C_SQN_W-1:0] i_invSqN,
   output logic               o_valid,
   output EX_UOp              o_uop,
   output logic [NUM_XUS-1:0] o_en,
   output logic               o_ready
);

   logic               r_outValid, r_skidValid;
   EX_UOp              r_outUop, r_skidUop;
   logic [NUM_XUS-1:0] r_outEn, r_skidEn;

   logic               w_outValid, w_skidValid;
   EX_UOp              w_outUop, w_skidUop;
   logic [NUM_XUS-1:0] w_outEn, w_skidEn;
   logic               w_inKeep, w_outKeep, w_skidKeep;

   always_comb begin
      w_inKeep    = i_valid && !r_skidValid && !(i_inv && is_younger(i_uop.sqN, i_invSqN));
      w_outKeep   = r_outValid && !(i_inv && is_younger(r_outUop.sqN, i_invSqN));
      w_skidKeep  = r_skidValid && !(i_inv && is_younger(r_skidUop.sqN, i_invSqN));
      w_outValid  = r_outValid;
      w_outUop    = r_outUop;
      w_outEn     = r_outEn;
      w_skidValid = r_skidValid;
      w_skidUop   = r_skidUop;
      w_skidEn    = r_skidEn;
      if (w_outKeep && !i_ready) begin
         // Output is held: only the skid slot can change.
         if (r_skidValid) begin
            w_skidValid = w_skidKeep;
         end else begin
            w_skidValid = w_inKeep;
            w_skidUop   = i_uop;
            w_skidEn    = i_en;
         end
      end else if (w_skidKeep) begin
         w_outValid  = 1'b1;
         w_outUop    = r_skidUop;
         w_outEn     = r_skidEn;
         w_skidValid = 1'b0;
      end else if (w_inKeep) begin
         w_outValid  = 1'b1;
         w_outUop    = i_uop;
         w_outEn     = i_en;
         w_skidValid = 1'b0;
      end else begin
         w_outValid  = 1'b0;
         w_skidValid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid  <= 1'b0;
         r_skidValid <= 1'b0;
         r_outEn     <= '0;
      end else begin
         r_outValid  <= w_outValid;
         r_skidValid <= w_skidValid;
         r_outEn     <= w_outEn;
      end
   end

   always_ff @(posedge clk) begin
      r_outUop  <= w_outUop;
      r_skidUop <= w_skidUop;
      r_skidEn  <= w_skidEn;
   end

   assign o_valid = r_outValid;
   assign o_uop   = r_outUop;
   assign o_en    = r_outEn;
   assign o_ready = !r_skidValid;

endmodule

`default_nettype wire

// File: rtl/operand_stage.sv
// operand_stage: per-port operand resolution (zero-cycle forward, writeback
// snoop, register file) feeding an independent output/skid buffer per port.
`default_nettype none

module operand_stage
   import operand_stage_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int NUM_WBS   = 3,
   parameter int NUM_ZC    = 2,
   parameter int NUM_XUS   = 4,
   parameter int TAG_W     = 6,
   parameter int XLEN      = 32,
   parameter int SQN_W     = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               IN_valid        [NUM_PORTS],
   output logic               OUT_ready       [NUM_PORTS],
   input  R_UOp               IN_uop          [NUM_PORTS],
   input  logic               IN_wbValid      [NUM_WBS],
   input  RES_UOp             IN_wbUOp        [NUM_WBS],
   input  logic               IN_zcValid      [NUM_ZC],
   input  logic [TAG_W-1:0]   IN_zcTag        [NUM_ZC],
   input  logic [XLEN-1:0]    IN_zcData       [NUM_ZC],
   input  logic               IN_invalidate,
   input  logic [SQN_W-1:0]   IN_invalidateSqN,
   output logic [TAG_W-1:0]   OUT_rfAddr      [2*NUM_PORTS],
   input  logic [XLEN-1:0]    IN_rfData       [2*NUM_PORTS],
   output logic               OUT_valid       [NUM_PORTS],
   input  logic               IN_ready        [NUM_PORTS],
   output EX_UOp              OUT_uop         [NUM_PORTS],
   output logic [NUM_XUS-1:0] OUT_enableXU    [NUM_PORTS]
);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [XLEN-1:0]    w_srcA, w_srcB;
      EX_UOp              w_ex;
      logic [NUM_XUS-1:0] w_en;

      assign OUT_rfAddr[p]           = IN_uop[p].tagA;
      assign OUT_rfAddr[p+NUM_PORTS] = IN_uop[p].tagB;

      // Sources are applied lowest priority first, and each loop runs from the
      // highest index down, so the lowest-index match is the one that sticks.
      always_comb begin
         w_srcA = IN_rfData[p];
         w_srcB = IN_rfData[p+NUM_PORTS];
         for (int i = NUM_WBS - 1; i >= 0; i--) begin
            if (IN_wbValid[i] && IN_wbUOp[i].tagDst == IN_uop[p].tagA) w_srcA = IN_wbUOp[i].result;
            if (IN_wbValid[i] && IN_wbUOp[i].tagDst == IN_uop[p].tagB) w_srcB = IN_wbUOp[i].result;
         end
         for (int i = NUM_ZC - 1; i >= 0; i--) begin
            if (IN_zcValid[i] && IN_zcTag[i] == IN_uop[p].tagA) w_srcA = IN_zcData[i];
            if (IN_zcValid[i] && IN_zcTag[i] == IN_uop[p].tagB) w_srcB = IN_zcData[i];
         end
         if (IN_uop[p].tagA == '0) w_srcA = '0;
         if (IN_uop[p].tagB == '0) w_srcB = '0;
         if (IN_uop[p].immB)       w_srcB = IN_uop[p].imm;
      end

      always_comb begin
         w_ex            = '0;
         w_ex.srcA       = w_srcA;
         w_ex.srcB       = w_srcB;
         w_ex.imm        = IN_uop[p].imm;
         w_ex.sqN        = IN_uop[p].sqN;
         w_ex.tagDst     = IN_uop[p].tagDst;
         w_ex.nmDst      = IN_uop[p].nmDst;
         w_ex.opcode     = IN_uop[p].opcode;
         w_ex.pc         = IN_uop[p].pc;
         w_ex.branchID   = IN_uop[p].branchID;
         w_ex.branchPred = IN_uop[p].branchPred;
         w_ex.loadSqN    = IN_uop[p].loadSqN;
         w_ex.storeSqN   = IN_uop[p].storeSqN;
         w_ex.compressed = IN_uop[p].compressed;
      end

      assign w_en = NUM_XUS'(fu_enable(IN_uop[p].fu));

      operand_skid #(
         .NUM_XUS (NUM_XUS)
      ) u_skid (
         .clk      (clk),
         .rst      (rst),
         .i_valid  (IN_valid[p]),
         .i_uop    (w_ex),
         .i_en     (w_en),
         .i_ready  (IN_ready[p]),
         .i_inv    (IN_invalidate),
         .i_invSqN (IN_invalidateSqN),
         .o_valid  (OUT_valid[p]),
         .o_uop    (OUT_uop[p]),
         .o_en     (OUT_enableXU[p]),
         .o_ready  (OUT_ready[p])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed checks of forwarding priority, skid buffering,
// flush/promotion, immediates, FU enables and reset.
`default_nettype none

module tb_operand_stage;
   import operand_stage_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         IN_valid   [3];
   logic         OUT_ready  [3];
   R_UOp         IN_uop     [3];
   logic         IN_wbValid [3];
   RES_UOp       IN_wbUOp   [3];
   logic         IN_zcValid [2];
   logic [5:0]   IN_zcTag   [2];
   logic [31:0]  IN_zcData  [2];
   logic         IN_invalidate;
   logic [5:0]   IN_invalidateSqN;
   logic [5:0]   OUT_rfAddr [6];
   logic [31:0]  IN_rfData  [6];
   logic         OUT_valid  [3];
   logic         IN_ready   [3];
   EX_UOp        OUT_uop    [3];
   logic [3:0]   OUT_enableXU [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   operand_stage dut (
      .clk              (clk),
      .rst              (rst),
      .IN_valid         (IN_valid),
      .OUT_ready        (OUT_ready),
      .IN_uop           (IN_uop),
      .IN_wbValid       (IN_wbValid),
      .IN_wbUOp         (IN_wbUOp),
      .IN_zcValid       (IN_zcValid),
      .IN_zcTag         (IN_zcTag),
      .IN_zcData        (IN_zcData),
      .IN_invalidate    (IN_invalidate),
      .IN_invalidateSqN (IN_invalidateSqN),
      .OUT_rfAddr       (OUT_rfAddr),
      .IN_rfData        (IN_rfData),
      .OUT_valid        (OUT_valid),
      .IN_ready         (IN_ready),
      .OUT_uop          (OUT_uop),
      .OUT_enableXU     (OUT_enableXU)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic R_UOp mk(input logic [5:0] tA, input logic [5:0] tB, input logic [5:0] sq,
                               input FuncUnit fu, input logic iB, input logic [31:0] imm);
      R_UOp u;
      u        = '0;
      u.tagA   = tA;
      u.tagB   = tB;
      u.sqN    = sq;
      u.fu     = fu;
      u.immB   = iB;
      u.imm    = imm;
      u.pc     = 32'h1000 + 32'(sq);
      u.opcode = 6'h2A;
      u.tagDst = 6'd33;
      return u;
   endfunction

   task automatic clear_snoop();
      for (int i = 0; i < 3; i++) begin
         IN_wbValid[i] = 1'b0;
         IN_wbUOp[i]   = '0;
      end
      for (int i = 0; i < 2; i++) begin
         IN_zcValid[i] = 1'b0;
         IN_zcTag[i]   = '0;
         IN_zcData[i]  = '0;
      end
   endtask

   initial begin
      rst = 1'b1;
      IN_invalidate = 1'b0;
      IN_invalidateSqN = '0;
      for (int i = 0; i < 3; i++) begin
         IN_valid[i] = 1'b0;
         IN_ready[i] = 1'b1;
         IN_uop[i]   = '0;
      end
      for (int i = 0; i < 6; i++) IN_rfData[i] = 32'hCC;
      clear_snoop();
      tick();
      tick();
      chk("rst_valid", 64'(OUT_valid[0]), 64'd0);
      chk("rst_ready", 64'(OUT_ready[0]), 64'd1);
      chk("rst_en", 64'(OUT_enableXU[0]), 64'd0);
      rst = 1'b0;
      tick();

      // zero-cycle forward beats writeback beats register file
      IN_uop[0] = mk(6'd5, 6'd0, 6'd3, FU_INT, 1'b0, 32'h0);
      IN_valid[0] = 1'b1;
      IN_wbValid[0] = 1'b1; IN_wbUOp[0].tagDst = 6'd5; IN_wbUOp[0].result = 32'hAA;
      IN_zcValid[1] = 1'b1; IN_zcTag[1] = 6'd5; IN_zcData[1] = 32'hBB;
      #1;
      chk("rfAddrA", 64'(OUT_rfAddr[0]), 64'd5);
      chk("rfAddrB", 64'(OUT_rfAddr[3]), 64'd0);
      tick();
      IN_valid[0] = 1'b0; clear_snoop();
      chk("zc_valid", 64'(OUT_valid[0]), 64'd1);
      chk("zc_srcA", 64'(OUT_uop[0].srcA), 64'hBB);
      chk("zc_srcB_tag0", 64'(OUT_uop[0].srcB), 64'd0);
      chk("zc_en_int", 64'(OUT_enableXU[0]), 64'b0001);
      chk("zc_pc", 64'(OUT_uop[0].pc), 64'h1003);
      tick();
      chk("zc_drained", 64'(OUT_valid[0]), 64'd0);

      // lowest-index writeback wins; unmatched tag reads register file
      IN_uop[0] = mk(6'd9, 6'd12, 6'd4, FU_MUL, 1'b0, 32'h0);
      IN_valid[0] = 1'b1;
      IN_wbValid[1] = 1'b1; IN_wbUOp[1].tagDst = 6'd9; IN_wbUOp[1].result = 32'h11;
      IN_wbValid[2] = 1'b1; IN_wbUOp[2].tagDst = 6'd9; IN_wbUOp[2].result = 32'h22;
      IN_rfData[3] = 32'h3C;
      tick();
      IN_valid[0] = 1'b0; clear_snoop();
      chk("wb_srcA", 64'(OUT_uop[0].srcA), 64'h11);
      chk("rf_srcB", 64'(OUT_uop[0].srcB), 64'h3C);
      chk("mul_en", 64'(OUT_enableXU[0]), 64'b0100);
      tick();

      // stall for three cycles while two uops arrive
      IN_ready[0] = 1'b0;
      IN_uop[0] = mk(6'd0, 6'd0, 6'd20, FU_INT, 1'b0, 32'h0); IN_valid[0] = 1'b1;
      tick();
      chk("stall1_sq", 64'(OUT_uop[0].sqN), 64'd20);
      chk("stall1_ready", 64'(OUT_ready[0]), 64'd1);
      IN_uop[0] = mk(6'd0, 6'd0, 6'd21, FU_LSU, 1'b0, 32'h0);
      tick();
      IN_valid[0] = 1'b0;
      chk("stall2_sq", 64'(OUT_uop[0].sqN), 64'd20);
      chk("stall2_ready", 64'(OUT_ready[0]), 64'd0);
      tick();
      chk("stall3_sq", 64'(OUT_uop[0].sqN), 64'd20);
      chk("stall3_en", 64'(OUT_enableXU[0]), 64'b0001);
      chk("stall3_ready", 64'(OUT_ready[0]), 64'd0);
      IN_ready[0] = 1'b1;
      tick();
      chk("order_valid", 64'(OUT_valid[0]), 64'd1);
      chk("order_sq", 64'(OUT_uop[0].sqN), 64'd21);
      chk("order_en", 64'(OUT_enableXU[0]), 64'b0010);
      chk("order_ready", 64'(OUT_ready[0]), 64'd1);
      tick();
      chk("order_drained", 64'(OUT_valid[0]), 64'd0);

      // wrap-around flush: out 62 kept, skid 1 cleared by invalidate 63
      IN_ready[0] = 1'b0;
      IN_uop[0] = mk(6'd0, 6'd0, 6'd62, FU_INT, 1'b0, 32'h0); IN_valid[0] = 1'b1;
      tick();
      IN_uop[0] = mk(6'd0, 6'd0, 6'd1, FU_INT, 1'b0, 32'h0);
      tick();
      IN_valid[0] = 1'b0;
      IN_invalidate = 1'b1; IN_invalidateSqN = 6'd63;
      tick();
      IN_invalidate = 1'b0;
      chk("wrap_valid", 64'(OUT_valid[0]), 64'd1);
      chk("wrap_sq", 64'(OUT_uop[0].sqN), 64'd62);
      chk("wrap_ready", 64'(OUT_ready[0]), 64'd1);
      IN_ready[0] = 1'b1;
      tick();
      chk("wrap_drained", 64'(OUT_valid[0]), 64'd0);

      // out 10 flushed, skid 8 promoted on the same edge
      IN_ready[0] = 1'b0;
      IN_uop[0] = mk(6'd0, 6'd0, 6'd10, FU_INT, 1'b0, 32'h0); IN_valid[0] = 1'b1;
      tick();
      IN_uop[0] = mk(6'd0, 6'd0, 6'd8, FU_INT, 1'b0, 32'h0);
      tick();
      IN_valid[0] = 1'b0;
      IN_invalidate = 1'b1; IN_invalidateSqN = 6'd9;
      tick();
      IN_invalidate = 1'b0;
      chk("promote_valid", 64'(OUT_valid[0]), 64'd1);
      chk("promote_sq", 64'(OUT_uop[0].sqN), 64'd8);
      chk("promote_ready", 64'(OUT_ready[0]), 64'd1);
      IN_ready[0] = 1'b1;
      tick();

      // incoming younger uop dropped; equal sqN kept
      IN_uop[0] = mk(6'd0, 6'd0, 6'd30, FU_INT, 1'b0, 32'h0); IN_valid[0] = 1'b1;
      IN_invalidate = 1'b1; IN_invalidateSqN = 6'd25;
      tick();
      chk("in_flush", 64'(OUT_valid[0]), 64'd0);
      IN_uop[0] = mk(6'd0, 6'd0, 6'd25, FU_INT, 1'b0, 32'h0);
      tick();
      IN_invalidate = 1'b0;
      chk("in_equal_kept", 64'(OUT_valid[0]), 64'd1);

      // immediate overrides forwarded operand B; divider enable
      IN_uop[0] = mk(6'd0, 6'd7, 6'd40, FU_DIV, 1'b1, 32'h123);
      IN_wbValid[0] = 1'b1; IN_wbUOp[0].tagDst = 6'd7; IN_wbUOp[0].result = 32'h777;
      IN_rfData[3] = 32'h999;
      tick();
      clear_snoop();
      chk("imm_srcB", 64'(OUT_uop[0].srcB), 64'h123);
      chk("div_en", 64'(OUT_enableXU[0]), 64'b1000);
      IN_uop[0] = mk(6'd0, 6'd0, 6'd41, FU_BRANCH, 1'b0, 32'h0);
      tick();
      IN_valid[0] = 1'b0;
      chk("other_valid", 64'(OUT_valid[0]), 64'd1);
      chk("other_en", 64'(OUT_enableXU[0]), 64'd0);
      tick();

      // fill port 0, then show port 1 still flows
      IN_ready[0] = 1'b0;
      IN_uop[0] = mk(6'd0, 6'd0, 6'd50, FU_INT, 1'b0, 32'h0); IN_valid[0] = 1'b1;
      tick();
      IN_uop[0] = mk(6'd0, 6'd0, 6'd51, FU_INT, 1'b0, 32'h0);
      tick();
      chk("full_ready", 64'(OUT_ready[0]), 64'd0);
      IN_uop[1] = mk(6'd3, 6'd0, 6'd5, FU_LSU, 1'b0, 32'h0); IN_valid[1] = 1'b1;
      IN_rfData[1] = 32'h55;
      tick();
      IN_valid[1] = 1'b0;
      chk("p1_valid", 64'(OUT_valid[1]), 64'd1);
      chk("p1_srcA", 64'(OUT_uop[1].srcA), 64'h55);

      // reset beats invalidate and handshakes
      rst = 1'b1;
      IN_invalidate = 1'b1; IN_invalidateSqN = 6'd0;
      IN_uop[0] = mk(6'd0, 6'd0, 6'd52, FU_INT, 1'b0, 32'h0);
      tick();
      chk("rst2_valid", 64'(OUT_valid[0]), 64'd0);
      chk("rst2_ready", 64'(OUT_ready[0]), 64'd1);
      chk("rst2_en", 64'(OUT_enableXU[0]), 64'd0);
      chk("rst2_p1_valid", 64'(OUT_valid[1]), 64'd0);
      rst = 1'b0;
      IN_invalidate = 1'b0;
      IN_valid[0] = 1'b0;
      tick();
      chk("post_rst_valid", 64'(OUT_valid[0]), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, meaning independent issue ports.
REQ-002 SHALL have parameter NUM_WBS, default 3, meaning snooped writeback buses.
REQ-003 SHALL have parameter NUM_ZC, default 2, meaning zero-cycle forward sources.
REQ-004 SHALL have parameter NUM_XUS, default 4, meaning execution units addressed by one-hot enable.
REQ-005 SHALL have parameters TAG_W 6, XLEN 32 and SQN_W 6: physical tag, data and sequence-number widths.
REQ-006 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have ports IN_valid[NUM_PORTS] input 1 and OUT_ready[NUM_PORTS] output 1: per-port upstream handshake.
REQ-009 SHALL have port IN_uop[NUM_PORTS], input, R_UOp: issued uop.
REQ-010 SHALL have ports IN_wbValid[NUM_WBS] input 1 and IN_wbUOp[NUM_WBS] input RES_UOp: writeback snoop.
REQ-011 SHALL have ports IN_zcValid[NUM_ZC] input 1, IN_zcTag[NUM_ZC] input TAG_W and IN_zcData[NUM_ZC] input XLEN.
REQ-012 SHALL have ports IN_invalidate input 1 and IN_invalidateSqN input SQN_W: flush request.
REQ-013 SHALL have ports OUT_rfAddr[2*NUM_PORTS] output TAG_W and IN_rfData[2*NUM_PORTS] input XLEN: same-cycle register-file read, operand A at index p, operand B at index p+NUM_PORTS.
REQ-014 SHALL have ports OUT_valid[NUM_PORTS] output 1 and IN_ready[NUM_PORTS] input 1: per-port downstream handshake.
REQ-015 SHALL have ports OUT_uop[NUM_PORTS] output EX_UOp and OUT_enableXU[NUM_PORTS] output NUM_XUS.

Function
REQ-016 SHALL drive OUT_rfAddr combinationally from IN_uop tagA and tagB of the same port.
REQ-017 SHALL accept a uop when IN_valid && OUT_ready, and SHALL produce it at OUT_valid exactly 1 cycle later if the output stage is free.
REQ-018 SHALL give each port an output register and one skid entry; OUT_ready = skid empty, registered.
REQ-019 SHALL, when the output is held (OUT_valid && !IN_ready) and a uop is accepted, place it in the skid entry; the skid entry SHALL move to the output on the next transfer, preserving order.
REQ-020 SHALL resolve each operand at accept time: tag 0 gives 0; else the lowest-index valid zero-cycle match; else the lowest-index valid writeback match on tagDst; else IN_rfData.
REQ-021 SHALL use imm as srcB when immB is set, overriding all operand-B sources.
REQ-022 SHALL NOT re-resolve operands held in output or skid registers.
REQ-023 SHALL copy imm, sqN, tagDst, nmDst, opcode, pc, branchID, branchPred, loadSqN, storeSqN and compressed unchanged.
REQ-024 SHALL set OUT_enableXU one-hot: FU_INT bit0, FU_LSU bit1, FU_MUL bit2, FU_DIV bit3; any other fu SHALL give all-zero enable with the uop still valid.
REQ-025 SHALL treat an entry as younger when $signed(sqN - IN_invalidateSqN) > 0 over SQN_W bits, so wrap-around is correct.
REQ-026 SHALL, on IN_invalidate, drop a younger incoming uop and clear younger output and skid entries in the same edge; older or equal entries SHALL be kept.
REQ-027 SHALL, when a flush removes the output entry while the skid entry survives, promote the skid entry to the output on that edge.
REQ-028 SHALL keep OUT_uop and OUT_enableXU stable while OUT_valid && !IN_ready.
REQ-029 SHALL keep ports fully independent, with no cross-port stalls.

Reset
REQ-030 SHALL on rst clear OUT_valid, the skid valid bits and OUT_enableXU, and set OUT_ready to 1; data fields are don't-care.
REQ-031 SHALL let rst override IN_invalidate and any handshake in the same cycle.

Structure
REQ-032 SHALL take R_UOp, EX_UOp, RES_UOp and FuncUnit from the shared package, plus new constants for the FU-to-enable mapping.
REQ-033 SHALL instantiate one sub-module, operand_skid, once per port, holding the output and skid registers and the flush logic.

Verification
REQ-034 SHALL cover: tagA=5, wb0 tagDst=5 result=0xAA and zc1 tag=5 data=0xBB in the same cycle -> srcA=0xBB, OUT_valid after 1 cycle.
REQ-035 SHALL cover: IN_ready=0 for 3 cycles while 2 uops arrive -> first on output, second in skid, OUT_ready=0, in-order delivery after IN_ready=1.
REQ-036 SHALL cover: output sqN=62 and skid sqN=1, invalidate with sqN=63 -> output kept, skid cleared.
REQ-037 SHALL cover: output sqN=10 and skid sqN=8, invalidate with sqN=9 -> skid promoted to output on the same edge.
REQ-038 SHALL cover: immB=1, imm=0x123, tagB=7 with wb on tag 7 -> srcB=0x123; fu=FU_DIV -> enableXU=4'b1000.
REQ-039 SHALL cover: rst asserted with full skid and invalidate -> all valid bits 0 and OUT_ready=1 the next cycle.
